// File: rtl/mips_defs.sv
// mips_defs: opcodes and access-size type shared by the MEM stage
package mips_defs;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;
    typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_t;
endpackage

// File: rtl/dm_ram.sv
// dm_ram: word array with async read, byte-enable sync write, async clear
module dm_ram #(
    parameter int DM_WORDS = 1024,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [31:0] mem [DM_WORDS];
    assign rdata = mem[addr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
        end else if (we) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage with data memory, load extension and MEM/WB registers
module mem_stage
    import mips_defs::*;
#(
    parameter int DM_WORDS = 1024,
    parameter int ADDR_W   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr_M,
    input  logic [31:0] RT_M,
    input  logic [31:0] ALU_M,
    input  logic [31:0] EXT_M,
    input  logic [31:0] PC8_M,
    input  logic [4:0]  WBA_M,
    output logic [31:0] Instr_W,
    output logic [31:0] ALU_W,
    output logic [31:0] EXT_W,
    output logic [31:0] PC8_W,
    output logic [4:0]  WBA_W,
    output logic [31:0] DM_W,
    output logic        AdEL_W,
    output logic        AdES_W
);
    logic [5:0]  op;
    logic        is_load, is_store, misalign, we;
    size_t       sz;
    logic [3:0]  be;
    logic [31:0] wdata, rdata, load_v;
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    assign op = Instr_M[31:26];
    always_comb begin
        is_load  = op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
        is_store = op inside {OP_SW, OP_SH, OP_SB};
        sz = (op == OP_LW || op == OP_SW) ? SZ_WORD :
             (op == OP_LH || op == OP_LHU || op == OP_SH) ? SZ_HALF : SZ_BYTE;
        misalign = (sz == SZ_WORD && ALU_M[1:0] != 2'b00) || (sz == SZ_HALF && ALU_M[0]);
        we = is_store && !misalign;
        // replicate the store data across lanes; the byte enables pick the target
        wdata = sz == SZ_WORD ? RT_M : sz == SZ_HALF ? {2{RT_M[15:0]}} : {4{RT_M[7:0]}};
        be = sz == SZ_WORD ? 4'hF : sz == SZ_HALF ? (ALU_M[1] ? 4'hC : 4'h3) : 4'b0001 << ALU_M[1:0];
        half_v = ALU_M[1] ? rdata[31:16] : rdata[15:0];
        byte_v = 8'(rdata >> {ALU_M[1:0], 3'b000});
        load_v = op == OP_LW  ? rdata :
                 op == OP_LH  ? {{16{half_v[15]}}, half_v} :
                 op == OP_LHU ? {16'h0, half_v} :
                 op == OP_LB  ? {{24{byte_v[7]}}, byte_v} :
                 op == OP_LBU ? {24'h0, byte_v} : 32'h0;
    end
    dm_ram #(.DM_WORDS(DM_WORDS), .ADDR_W(ADDR_W)) u_ram (
        .clk(clk),
        .rst(rst),
        .addr(ALU_M[ADDR_W+1:2]),
        .we(we),
        .be(be),
        .wdata(wdata),
        .rdata(rdata)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Instr_W <= '0;
            ALU_W   <= '0;
            EXT_W   <= '0;
            PC8_W   <= '0;
            WBA_W   <= '0;
            DM_W    <= '0;
            AdEL_W  <= 1'b0;
            AdES_W  <= 1'b0;
        end else begin
            Instr_W <= Instr_M;
            ALU_W   <= ALU_M;
            EXT_W   <= EXT_M;
            PC8_W   <= PC8_M;
            WBA_W   <= (is_load && misalign) ? 5'd0 : WBA_M;
            DM_W    <= (is_load && !misalign) ? load_v : 32'h0;
            AdEL_W  <= is_load && misalign;
            AdES_W  <= is_store && misalign;
        end
    end
endmodule
